pipe_datapath_fwd: RTL and testbench

Parametrised two-stage (execute / writeback) CPU datapath with an internal register file, ALU and data-memory port. It is the successor to the fixed 32-bit pipelined datapath. It adds configurable widths, writeback-to-execute operand forwarding, stall and flush control, a valid bit per stage, selectable sign/zero extension, and a hardwired-zero register 0. It sits between the decode/control unit and the data memory.

---
 rtl/pipe_datapath_fwd.sv | 111 +++++++++++
 tb/tb_pipe_datapath_fwd.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_datapath_fwd.sv
// pipe_datapath_fwd: two-stage execute/writeback datapath with WB-to-EX forwarding, stall, flush and hardwired r0
module pipe_datapath_fwd #(
  parameter int DATA_W = 32,
  parameter int RADR_W = 5,
  parameter int IMM_W = 16,
  parameter int MEM_W = 16,
  parameter int MADR_W = 11,
  parameter int SHORT_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               dec_valid,
  input  logic [IMM_W-1:0]   dec_imm,
  input  logic               dec_imm_sext,
  input  logic [RADR_W-1:0]  dec_rd_adrx0,
  input  logic [RADR_W-1:0]  dec_rd_adrx1,
  input  logic [RADR_W-1:0]  dec_wr_adrx,
  input  logic               dec_reg_dest,
  input  logic [2:0]         dec_alu_ctl,
  input  logic               dec_alu_b_sel,
  input  logic               dec_rf_write_en,
  input  logic               dec_dmem_result_sel,
  input  logic               dec_dmem_sext,
  input  logic               dec_dmem_write_en,
  input  logic [MEM_W-1:0]   dmem_output,
  output logic [MADR_W-1:0]  dmem_addr,
  output logic [MEM_W-1:0]   dmem_data_in,
  output logic               dmem_write_en,
  output logic               ex_c_flag,
  output logic               ex_n_flag,
  output logic               ex_v_flag,
  output logic               ex_z_flag,
  output logic [SHORT_W-1:0] ex_rd_data0_short,
  output logic               ex_valid
);
  localparam int SH_W = $clog2(DATA_W);
  localparam int NREG = 2 ** RADR_W;
  logic [DATA_W-1:0] rf [NREG];
  logic [DATA_W-1:0] wb_res, wb_data, op_a, op_b, imm_ext, alu_b, b_add, alu_res;
  logic [DATA_W:0] sum;
  logic [MEM_W-1:0] wb_mem;
  logic [RADR_W-1:0] wb_dest, dest;
  logic [SH_W-1:0] shamt;
  logic wb_we, wb_rsel, wb_msext, accept, wb_commit, fwd_a, fwd_b, is_sub, arith, ovf;
  assign wb_data = wb_rsel ? (wb_msext ? DATA_W'($signed(wb_mem)) : DATA_W'(wb_mem)) : wb_res;
  assign wb_commit = ex_valid & wb_we & (wb_dest != '0);
  assign fwd_a = wb_commit & (wb_dest == dec_rd_adrx0);
  assign fwd_b = wb_commit & (wb_dest == dec_rd_adrx1);
  assign op_a = fwd_a ? wb_data : (dec_rd_adrx0 == '0 ? '0 : rf[dec_rd_adrx0]);
  assign op_b = fwd_b ? wb_data : (dec_rd_adrx1 == '0 ? '0 : rf[dec_rd_adrx1]);
  assign imm_ext = dec_imm_sext ? DATA_W'($signed(dec_imm)) : DATA_W'(dec_imm);
  assign alu_b = dec_alu_b_sel ? imm_ext : op_b;
  assign is_sub = dec_alu_ctl == 3'd1;
  assign arith = dec_alu_ctl == 3'd0 || is_sub;
  assign b_add = is_sub ? ~alu_b : alu_b;
  assign sum = {1'b0, op_a} + {1'b0, b_add} + (DATA_W+1)'(is_sub);
  assign ovf = (op_a[DATA_W-1] == b_add[DATA_W-1]) & (sum[DATA_W-1] != op_a[DATA_W-1]);
  assign shamt = alu_b[SH_W-1:0];
  assign alu_res = dec_alu_ctl == 3'd2 ? op_a & alu_b :
                   dec_alu_ctl == 3'd3 ? op_a | alu_b :
                   dec_alu_ctl == 3'd4 ? op_a ^ alu_b :
                   dec_alu_ctl == 3'd5 ? DATA_W'($signed(op_a) < $signed(alu_b)) :
                   dec_alu_ctl == 3'd6 ? op_a << shamt :
                   dec_alu_ctl == 3'd7 ? $unsigned($signed(op_a) >>> shamt) :
                   sum[DATA_W-1:0];
  assign dest = dec_reg_dest ? dec_wr_adrx : dec_rd_adrx1;
  assign accept = dec_valid & ~stall & ~flush;
  assign dmem_addr = alu_res[MADR_W-1:0];
  assign dmem_data_in = op_b[MEM_W-1:0];
  assign dmem_write_en = accept & dec_dmem_write_en;
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid <= 1'b0;
      wb_res <= '0;
      wb_mem <= '0;
      wb_dest <= '0;
      wb_we <= 1'b0;
      wb_rsel <= 1'b0;
      wb_msext <= 1'b0;
      ex_c_flag <= 1'b0;
      ex_n_flag <= 1'b0;
      ex_v_flag <= 1'b0;
      ex_z_flag <= 1'b0;
      ex_rd_data0_short <= '0;
    end else if (!stall) begin
      ex_valid <= accept;
      wb_we <= accept & dec_rf_write_en;
      if (accept) begin
        wb_res <= alu_res;
        wb_mem <= dmem_output;
        wb_dest <= dest;
        wb_rsel <= dec_dmem_result_sel;
        wb_msext <= dec_dmem_sext;
        ex_c_flag <= arith & sum[DATA_W];
        ex_n_flag <= alu_res[DATA_W-1];
        ex_v_flag <= arith & ovf;
        ex_z_flag <= alu_res == '0;
        ex_rd_data0_short <= op_a[SHORT_W-1:0];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (!stall && wb_commit) begin
      rf[wb_dest] <= wb_data;
    end
  end
endmodule

// File: tb/tb_pipe_datapath_fwd.sv
// tb_pipe_datapath_fwd: directed vector table, corner sequences and randomized model check of pipe_datapath_fwd
module tb_pipe_datapath_fwd;
  logic clk = 1'b0, reset, stall, flush, dec_valid, dec_imm_sext, dec_reg_dest, dec_alu_b_sel;
  logic dec_rf_write_en, dec_dmem_result_sel, dec_dmem_sext, dec_dmem_write_en;
  logic [15:0] dec_imm, dmem_output, dmem_data_in;
  logic [4:0] dec_rd_adrx0, dec_rd_adrx1, dec_wr_adrx;
  logic [2:0] dec_alu_ctl;
  logic [10:0] dmem_addr;
  logic dmem_write_en, ex_c_flag, ex_n_flag, ex_v_flag, ex_z_flag, ex_valid;
  logic [8:0] ex_rd_data0_short;
  logic [3:0] flags;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {
    logic v;
    logic [2:0] ctl;
    logic [4:0] a, b, w;
    logic rdst, bsel;
    logic [15:0] imm;
    logic isx, we, rsel, msx, dwe;
    logic [15:0] mem;
  } ins_t;
  typedef struct {
    ins_t i;
    logic [10:0] e_addr;
    logic [3:0] e_cnvz;
    logic [8:0] e_sh;
    logic [4:0] c_reg;
    logic [31:0] e_reg;
  } vec_t;
  vec_t tbl[$];
  logic [31:0] m [32];
  always #10 clk = ~clk;
  assign flags = {ex_c_flag, ex_n_flag, ex_v_flag, ex_z_flag};
  pipe_datapath_fwd dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .dec_valid(dec_valid),
    .dec_imm(dec_imm), .dec_imm_sext(dec_imm_sext), .dec_rd_adrx0(dec_rd_adrx0),
    .dec_rd_adrx1(dec_rd_adrx1), .dec_wr_adrx(dec_wr_adrx), .dec_reg_dest(dec_reg_dest),
    .dec_alu_ctl(dec_alu_ctl), .dec_alu_b_sel(dec_alu_b_sel), .dec_rf_write_en(dec_rf_write_en),
    .dec_dmem_result_sel(dec_dmem_result_sel), .dec_dmem_sext(dec_dmem_sext),
    .dec_dmem_write_en(dec_dmem_write_en), .dmem_output(dmem_output), .dmem_addr(dmem_addr),
    .dmem_data_in(dmem_data_in), .dmem_write_en(dmem_write_en), .ex_c_flag(ex_c_flag),
    .ex_n_flag(ex_n_flag), .ex_v_flag(ex_v_flag), .ex_z_flag(ex_z_flag),
    .ex_rd_data0_short(ex_rd_data0_short), .ex_valid(ex_valid)
  );
  function automatic ins_t mk(input logic [2:0] ctl, input logic [4:0] a, b, w, input logic bsel, input logic [15:0] imm, input logic isx);
    ins_t t;
    t = '0;
    t.v = 1'b1;
    t.ctl = ctl;
    t.a = a;
    t.b = b;
    t.w = w;
    t.rdst = 1'b1;
    t.bsel = bsel;
    t.imm = imm;
    t.isx = isx;
    t.we = 1'b1;
    return t;
  endfunction
  function automatic logic [31:0] ext16(input logic [15:0] x, input logic s);
    return s ? {{16{x[15]}}, x} : {16'h0, x};
  endfunction
  function automatic logic [33:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    logic [32:0] u;
    logic [31:0] r;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0;
    v = 1'b0;
    s = 0;
    r = '0;
    case (op)
      3'd0: begin u = {1'b0, a} + {1'b0, b}; r = u[31:0]; c = u[32]; s = sa + sb; v = s != longint'($signed(r)); end
      3'd1: begin r = a - b; c = a >= b; s = sa - sb; v = s != longint'($signed(r)); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: r = a << b[4:0];
      default: r = 32'(sa >>> b[4:0]);
    endcase
    return {c, v, r};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic apply(input ins_t t, input logic st, input logic fl);
    stall = st;
    flush = fl;
    dec_valid = t.v;
    dec_imm = t.imm;
    dec_imm_sext = t.isx;
    dec_rd_adrx0 = t.a;
    dec_rd_adrx1 = t.b;
    dec_wr_adrx = t.w;
    dec_reg_dest = t.rdst;
    dec_alu_ctl = t.ctl;
    dec_alu_b_sel = t.bsel;
    dec_rf_write_en = t.we;
    dec_dmem_result_sel = t.rsel;
    dec_dmem_sext = t.msx;
    dec_dmem_write_en = t.dwe;
    dmem_output = t.mem;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic peek(input logic [4:0] r, output logic [31:0] val);
    logic [10:0] p [3];
    ins_t t;
    for (int k = 0; k < 3; k++) begin
      t = mk(3'd7, r, 5'd0, 5'd0, 1'b1, 16'(11 * k), 1'b0);
      t.v = 1'b0;
      apply(t, 1'b0, 1'b0);
      #1;
      p[k] = dmem_addr;
    end
    val = {p[2][9:0], p[1], p[0]};
  endtask
  task automatic chk_reg(input string nm, input logic [4:0] r, input logic [31:0] exp);
    logic [31:0] v;
    peek(r, v);
    chk(nm, v, exp);
  endtask
  task automatic add(input ins_t i, input logic [10:0] a, input logic [3:0] f, input logic [8:0] s, input logic [4:0] r, input logic [31:0] v);
    tbl.push_back('{i, a, f, s, r, v});
  endtask
  task automatic do_reset();
    reset = 1'b1;
    apply('0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask
  initial begin
    ins_t t, bub;
    logic [33:0] ar;
    logic [31:0] va, vb, bi, wv;
    logic [4:0] dst;
    logic [3:0] mf;
    logic [8:0] msh;
    logic mv, st, fl;
    bub = '0;
    add(mk(0, 0, 0, 1, 1, 16'd5, 0), 11'h005, 4'b0000, 9'h000, 5'd1, 32'd5);
    add(mk(0, 1, 0, 2, 1, 16'd3, 0), 11'h008, 4'b0000, 9'h005, 5'd2, 32'd8);
    add(mk(0, 0, 0, 5, 1, 16'hFFFF, 1), 11'h7FF, 4'b0100, 9'h000, 5'd5, 32'hFFFFFFFF);
    add(mk(6, 5, 0, 6, 1, 16'd31, 0), 11'h000, 4'b0100, 9'h1FF, 5'd6, 32'h80000000);
    add(mk(1, 6, 0, 7, 1, 16'd1, 0), 11'h7FF, 4'b1010, 9'h000, 5'd7, 32'h7FFFFFFF);
    add(mk(0, 7, 0, 8, 1, 16'd1, 0), 11'h000, 4'b0110, 9'h1FF, 5'd8, 32'h80000000);
    add(mk(0, 0, 0, 9, 1, 16'd5, 0), 11'h005, 4'b0000, 9'h000, 5'd9, 32'd5);
    add(mk(1, 9, 9, 10, 0, 16'd0, 0), 11'h000, 4'b1001, 9'h005, 5'd10, 32'd0);
    t = mk(0, 0, 0, 3, 1, 16'h10, 0);
    t.rsel = 1'b1;
    t.msx = 1'b1;
    t.mem = 16'h8001;
    add(t, 11'h010, 4'b0000, 9'h000, 5'd3, 32'hFFFF8001);
    add(mk(0, 3, 0, 11, 1, 16'd1, 0), 11'h002, 4'b0100, 9'h001, 5'd11, 32'hFFFF8002);
    t.msx = 1'b0;
    add(t, 11'h010, 4'b0000, 9'h000, 5'd3, 32'h00008001);
    add(mk(0, 3, 0, 12, 1, 16'd1, 0), 11'h002, 4'b0000, 9'h001, 5'd12, 32'h00008002);
    add(mk(0, 0, 0, 0, 1, 16'h1234, 0), 11'h234, 4'b0000, 9'h000, 5'd0, 32'd0);
    add(mk(0, 0, 0, 13, 1, 16'd0, 0), 11'h000, 4'b0001, 9'h000, 5'd13, 32'd0);
    add(mk(0, 0, 0, 14, 1, 16'd7, 0), 11'h007, 4'b0000, 9'h000, 5'd14, 32'd7);
    add(mk(2, 5, 0, 15, 1, 16'h00F0, 0), 11'h0F0, 4'b0000, 9'h1FF, 5'd15, 32'h000000F0);
    add(mk(3, 15, 0, 16, 1, 16'h0F00, 0), 11'h7F0, 4'b0000, 9'h0F0, 5'd16, 32'h00000FF0);
    add(mk(4, 16, 0, 17, 1, 16'hFFFF, 1), 11'h00F, 4'b0100, 9'h1F0, 5'd17, 32'hFFFFF00F);
    add(mk(5, 5, 0, 18, 1, 16'd0, 0), 11'h001, 4'b0000, 9'h1FF, 5'd18, 32'd1);
    add(mk(5, 9, 5, 19, 0, 16'd0, 0), 11'h000, 4'b0001, 9'h005, 5'd19, 32'd0);
    add(mk(7, 6, 0, 20, 1, 16'd4, 0), 11'h000, 4'b0100, 9'h000, 5'd20, 32'hF8000000);
    t = mk(0, 9, 21, 21, 1, 16'd2, 0);
    t.rdst = 1'b0;
    add(t, 11'h007, 4'b0000, 9'h005, 5'd21, 32'd7);
    do_reset();
    chk("reset ex_valid", 32'(ex_valid), 32'd0);
    chk("reset flags", 32'(flags), 32'd0);
    chk("reset short", 32'(ex_rd_data0_short), 32'd0);
    foreach (tbl[n]) begin
      apply(tbl[n].i, 1'b0, 1'b0);
      #1;
      chk($sformatf("vec%0d addr", n), 32'(dmem_addr), 32'(tbl[n].e_addr));
      tick();
      chk($sformatf("vec%0d flags", n), 32'(flags), 32'(tbl[n].e_cnvz));
      chk($sformatf("vec%0d short", n), 32'(ex_rd_data0_short), 32'(tbl[n].e_sh));
      chk($sformatf("vec%0d ex_valid", n), 32'(ex_valid), 32'd1);
      chk_reg($sformatf("vec%0d reg", n), tbl[n].c_reg, tbl[n].e_reg);
    end
    apply(mk(0, 5, 0, 22, 1, 16'h56, 0), 1'b0, 1'b0);
    tick();
    chk("stall pre flags", 32'(flags), 32'b1000);
    chk("stall pre short", 32'(ex_rd_data0_short), 32'h1FF);
    for (int k = 0; k < 3; k++) begin
      t = mk(0, 0, 0, 23, 1, 16'd0, 0);
      t.dwe = 1'b1;
      apply(t, 1'b1, 1'b0);
      #1;
      chk("stall dmem_write_en", 32'(dmem_write_en), 32'd0);
      tick();
      chk("stall ex_valid", 32'(ex_valid), 32'd1);
      chk("stall flags", 32'(flags), 32'b1000);
      chk("stall short", 32'(ex_rd_data0_short), 32'h1FF);
    end
    apply(bub, 1'b0, 1'b0);
    tick();
    chk("release ex_valid", 32'(ex_valid), 32'd0);
    chk_reg("release r22", 5'd22, 32'h55);
    chk_reg("stalled r23", 5'd23, 32'd0);
    t = mk(0, 5, 0, 24, 1, 16'd0, 0);
    t.dwe = 1'b1;
    apply(t, 1'b0, 1'b1);
    #1;
    chk("flush dmem_write_en", 32'(dmem_write_en), 32'd0);
    tick();
    chk("flush ex_valid", 32'(ex_valid), 32'd0);
    chk("flush flags", 32'(flags), 32'b1000);
    chk("flush short", 32'(ex_rd_data0_short), 32'h1FF);
    chk_reg("flush r24", 5'd24, 32'd0);
    apply(mk(0, 0, 0, 25, 1, 16'd2, 0), 1'b0, 1'b0);
    tick();
    apply(mk(0, 5, 0, 26, 1, 16'd0, 0), 1'b1, 1'b1);
    tick();
    chk("stall over flush ex_valid", 32'(ex_valid), 32'd1);
    chk("stall over flush flags", 32'(flags), 32'b0000);
    apply(bub, 1'b0, 1'b0);
    tick();
    chk_reg("held r25", 5'd25, 32'd2);
    chk_reg("held r26", 5'd26, 32'd0);
    apply(mk(0, 5, 0, 4, 1, 16'd0, 0), 1'b0, 1'b0);
    tick();
    chk("pre reset flags", 32'(flags), 32'b0100);
    reset = 1'b1;
    apply(bub, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    chk("mid reset ex_valid", 32'(ex_valid), 32'd0);
    chk("mid reset flags", 32'(flags), 32'd0);
    chk("mid reset short", 32'(ex_rd_data0_short), 32'd0);
    chk_reg("mid reset r4", 5'd4, 32'd0);
    chk_reg("mid reset r5", 5'd5, 32'd0);
    apply(mk(0, 0, 0, 1, 1, 16'd3, 0), 1'b0, 1'b0);
    tick();
    chk("post reset ex_valid", 32'(ex_valid), 32'd1);
    chk_reg("post reset r1", 5'd1, 32'd3);
    do_reset();
    foreach (m[r]) m[r] = '0;
    mf = '0;
    msh = '0;
    mv = 1'b0;
    for (int n = 0; n < 400; n++) begin
      t = '0;
      t.v = $urandom_range(0, 9) != 0;
      t.ctl = 3'($urandom);
      t.a = 5'($urandom_range(0, 7));
      t.b = 5'($urandom_range(0, 7));
      t.w = 5'($urandom_range(0, 7));
      t.rdst = 1'($urandom);
      t.bsel = 1'($urandom);
      t.imm = 16'($urandom);
      t.isx = 1'($urandom);
      t.we = $urandom_range(0, 3) != 0;
      t.rsel = $urandom_range(0, 3) == 0;
      t.msx = 1'($urandom);
      t.dwe = $urandom_range(0, 3) == 0;
      t.mem = 16'($urandom);
      st = $urandom_range(0, 6) == 0;
      fl = $urandom_range(0, 7) == 0;
      apply(t, st, fl);
      #1;
      va = m[t.a];
      vb = m[t.b];
      bi = t.bsel ? ext16(t.imm, t.isx) : vb;
      ar = alu_ref(t.ctl, va, bi);
      chk("rand dmem_addr", 32'(dmem_addr), 32'(ar[10:0]));
      chk("rand dmem_data_in", 32'(dmem_data_in), 32'(vb[15:0]));
      chk("rand dmem_write_en", 32'(dmem_write_en), 32'(t.v & t.dwe & ~st & ~fl));
      tick();
      if (!st) begin
        mv = t.v & ~fl;
        if (mv) begin
          mf = {ar[33], ar[31], ar[32], ar[31:0] == 32'd0};
          msh = va[8:0];
          dst = t.rdst ? t.w : t.b;
          wv = t.rsel ? ext16(t.mem, t.msx) : ar[31:0];
          if (t.we && dst != 5'd0) m[dst] = wv;
        end
      end
      chk("rand flags", 32'(flags), 32'(mf));
      chk("rand short", 32'(ex_rd_data0_short), 32'(msh));
      chk("rand ex_valid", 32'(ex_valid), 32'(mv));
    end
    apply(bub, 1'b0, 1'b0);
    tick();
    for (int r = 0; r < 32; r++) begin
      tick();
      chk_reg($sformatf("final r%0d", r), 5'(r), m[r]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
